alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the 8-bit combinational ALU; the operand width is set by WIDTH.
- Adds status flags, true barrel shifts (SLL/SRL/SRA) and an iterative shift-add multiplier.
- The single registered output stage uses valid/ready on both sides.
- Sits between the operand-fetch stage and writeback. Each side can stall the other without losing data.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_mul.sv | 53 +++++
 rtl/alu_pipe.sv | 197 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode map and controller state encoding shared by the pipelined ALU and its bench.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_SLL = 4'd2;
    localparam logic [OP_W-1:0] OP_SRL = 4'd3;
    localparam logic [OP_W-1:0] OP_AND = 4'd4;
    localparam logic [OP_W-1:0] OP_OR  = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR = 4'd6;
    localparam logic [OP_W-1:0] OP_EQ  = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA = 4'd8;
    localparam logic [OP_W-1:0] OP_MUL = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } st_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: the first partial product is taken on start,
// the remaining WIDTH-1 on the following edges; done_o flags the completed product.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start_i) begin
            r_acc    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
            r_mplier <= b_i >> 1;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign done_o = r_busy && (r_cnt == '0);
    assign prod_o = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with one registered output stage, status flags, barrel shifts
// and an optional iterative multiplier that holds the input side while it runs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] alu_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             err_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output st_e              dbg_state_o
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    st_e              r_state;
    st_e              w_state_nxt;
    logic             r_run;
    logic [WIDTH-1:0] r_alu;
    logic             r_zero, r_neg, r_carry, r_ovf, r_err, r_out_valid;

    logic             w_accept, w_is_mul, w_mul_start, w_mul_done;
    logic [SH_W-1:0]  w_shamt;
    logic [WIDTH:0]   w_sum, w_diff, w_sll, w_srl, w_sra;
    logic [WIDTH-1:0] w_res, w_wr_res;
    logic             w_carry, w_ovf, w_err;
    logic             w_wr_en, w_wr_carry, w_wr_ovf, w_wr_err;
    logic [2*WIDTH-1:0] w_prod;

    // Handshake: a transfer happens on a rising edge where valid && ready on that side.
    // in_ready_o depends only on state and the output handshake, so a result can be
    // drained and a new op accepted on the same edge without a bubble.
    assign in_ready_o = r_run && (r_state == ST_IDLE) && (!r_out_valid || out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;

    assign w_shamt = b_i[SH_W-1:0];
    assign w_sum   = {1'b0, a_i} + {1'b0, b_i};
    assign w_diff  = {1'b0, a_i} - {1'b0, b_i};
    // One guard bit on the far side of each shift captures the last bit shifted out.
    assign w_sll   = {1'b0, a_i} << w_shamt;
    assign w_srl   = {a_i, 1'b0} >> w_shamt;
    assign w_sra   = $signed({a_i, 1'b0}) >>> w_shamt;

    always_comb begin
        w_res    = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_err    = 1'b0;
        w_is_mul = 1'b0;
        case (op_i)
            OP_ADD: begin
                w_res   = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a_i[MSB] == b_i[MSB]) && (w_sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                w_res   = w_diff[MSB:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (a_i[MSB] != b_i[MSB]) && (w_diff[MSB] != a_i[MSB]);
            end
            OP_SLL: begin
                w_res   = w_sll[MSB:0];
                w_carry = w_sll[WIDTH];
            end
            OP_SRL: begin
                w_res   = w_srl[WIDTH:1];
                w_carry = w_srl[0];
            end
            OP_SRA: begin
                w_res   = w_sra[WIDTH:1];
                w_carry = w_sra[0];
            end
            OP_AND:  w_res = a_i & b_i;
            OP_OR:   w_res = a_i | b_i;
            OP_XOR:  w_res = a_i ^ b_i;
            OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            OP_MUL: begin
                if (MUL_EN) begin
                    w_is_mul = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_res    = w_res;
        w_wr_carry  = w_carry;
        w_wr_ovf    = w_ovf;
        w_wr_err    = w_err;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = ST_BUSY;
                        w_mul_start = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (w_mul_done) begin
                    w_state_nxt = ST_IDLE;
                    w_wr_en     = 1'b1;
                    w_wr_res    = w_prod[MSB:0];
                    w_wr_carry  = 1'b0;
                    w_wr_ovf    = |w_prod[2*WIDTH-1:WIDTH];
                    w_wr_err    = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run       <= 1'b0;
            r_alu       <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_wr_en) begin
                r_out_valid <= 1'b1;
                r_alu       <= w_wr_res;
                r_zero      <= (w_wr_res == '0);
                r_neg       <= w_wr_res[MSB];
                r_carry     <= w_wr_carry;
                r_ovf       <= w_wr_ovf;
                r_err       <= w_wr_err;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_seq_mul #(
                .WIDTH(WIDTH)
            ) u_mul (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .start_i (w_mul_start),
                .a_i     (a_i),
                .b_i     (b_i),
                .done_o  (w_mul_done),
                .prod_o  (w_prod)
            );
        end else begin : g_no_mul
            assign w_mul_done = 1'b0;
            assign w_prod     = '0;
        end
    endgenerate

    assign alu_o        = r_alu;
    assign zero_o       = r_zero;
    assign neg_o        = r_neg;
    assign carry_o      = r_carry;
    assign ovf_o        = r_ovf;
    assign err_o        = r_err;
    assign out_valid_o  = r_out_valid;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int RW   = W + 5;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int TMO  = 64;

    logic            clk;
    logic            rst_ni;
    logic [W-1:0]    a_i, b_i;
    logic [OP_W-1:0] op_i;
    logic            in_valid_i, in_ready_o;
    logic [W-1:0]    alu_o;
    logic            zero_o, neg_o, carry_o, ovf_o, err_o;
    logic            out_valid_o, out_ready_i;
    st_e             dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] last_obs;
    int last_lat;
    int last_stall;

    alu_pipe #(
        .WIDTH  (W),
        .MUL_EN (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .alu_o       (alu_o),
        .zero_o      (zero_o),
        .neg_o       (neg_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o),
        .err_o       (err_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [RW-1:0] obs();
        return {alu_o, zero_o, neg_o, carry_o, ovf_o, err_o};
    endfunction

    // Reference: integer arithmetic on the operand values, reduced modulo 2^W.
    function automatic logic [RW-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [OP_W-1:0] op);
        int ua, ub, sa, sb, sh, r;
        logic c, v, e;
        logic [W-1:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        sh = ub % W;
        r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (int'(op))
            0: begin r = ua + ub; c = (r >= FULL); v = (sa + sb >= HALF) || (sa + sb < -HALF); end
            1: begin r = ua - ub; c = (ua < ub);   v = (sa - sb >= HALF) || (sa - sb < -HALF); end
            2: begin r = ua << sh; c = ((r >> W) & 1) != 0; end
            3: begin r = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            4: r = ua & ub;
            5: r = ua | ub;
            6: r = ua ^ ub;
            7: r = (ua == ub) ? 1 : 0;
            8: begin r = sa >>> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            9: begin r = ua * ub; v = (r >= FULL); end
            default: e = 1'b1;
        endcase
        r = r & (FULL - 1);
        res = r[W-1:0];
        return {res, (res == '0), res[W-1], c, v, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        assert (got === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    // driver: present an op and hold it until accepted; ends 1 time unit after the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OP_W-1:0] op);
        int n;
        a_i = a;
        b_i = b;
        op_i = op;
        in_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        exp_q.push_back(ref_model(a, b, op));
    endtask

    // scoreboard side: last_lat counts negedge samples after the accept edge up to and
    // including the first one with out_valid high; last_stall counts those with in_ready low
    task automatic receive(input string tag);
        logic [RW-1:0] exp_v;
        int n;
        n = 1;
        last_stall = 0;
        @(negedge clk);
        while (!out_valid_o && n < TMO) begin
            if (!in_ready_o) last_stall++;
            @(negedge clk);
            n++;
        end
        last_lat = n;
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        exp_v = '0;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        last_obs = obs();
        chk({tag, "_data"}, 32'(last_obs), 32'(exp_v));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [OP_W-1:0] op, input logic [RW-1:0] hand_exp,
                            input int exp_lat);
        send(a, b, op);
        receive(tag);
        chk({tag, "_latency"}, 32'(last_lat), 32'(exp_lat));
        chk({tag, "_const"}, 32'(last_obs), 32'(hand_exp));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [OP_W-1:0] rop;
        int stall_cycles;
        int stray;

        rst_ni = 1'b1;
        a_i = '0;
        b_i = '0;
        op_i = '0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({in_ready_o, out_valid_o, obs()}), 32'd0);
        chk("reset_state", 32'(dbg_state_o), 32'(ST_IDLE));
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(in_ready_o), 32'd1);

        // Test 1..3: single-cycle ops, flags {res,zero,neg,carry,ovf,err}
        directed("t1_add_wrap", 8'hFF, 8'h01, OP_ADD, {8'h00, 5'b10100}, 1);
        directed("t2_sub_ovf",  8'h80, 8'h01, OP_SUB, {8'h7F, 5'b00010}, 1);
        directed("t2_sub_brw",  8'h01, 8'h02, OP_SUB, {8'hFF, 5'b01100}, 1);
        directed("t3_sll",      8'h81, 8'h01, OP_SLL, {8'h02, 5'b00100}, 1);
        directed("t3_sra",      8'h80, 8'h03, OP_SRA, {8'hF0, 5'b01000}, 1);
        directed("t3_srl",      8'h82, 8'h09, OP_SRL, {8'h41, 5'b00000}, 1);
        directed("eq_true",     8'h3C, 8'h3C, OP_EQ,  {8'h01, 5'b00000}, 1);

        // Test 4: multiplier, out_valid rises on the W-th edge after accept
        directed("t4_mul_ff", 8'h0F, 8'h11, OP_MUL, {8'hFF, 5'b01000}, W + 1);
        chk("t4_mul_busy_cycles", 32'(last_stall), 32'(W));
        directed("t4_mul_ovf", 8'h10, 8'h10, OP_MUL, {8'h00, 5'b10010}, W + 1);

        // Test 5: backpressure then same-edge drain and accept
        out_ready_i = 1'b0;
        send(8'h05, 8'h06, OP_ADD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(obs()), 32'(exp_q[0]));
            chk("bp_hold_ctl", 32'({out_valid_o, in_ready_o}), 32'(2'b10));
        end
        #1;
        out_ready_i = 1'b1;
        a_i = 8'hA5;
        b_i = 8'h5A;
        op_i = OP_XOR;
        in_valid_i = 1'b1;
        #1 chk("bp_ready_with_drain", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(ref_model(8'hA5, 8'h5A, OP_XOR));
        receive("bp_new");
        chk("bp_new_latency", 32'(last_lat), 32'd1);
        chk("bp_new_const", 32'(last_obs), 32'({8'hFF, 5'b01000}));

        // Test 6: reset in BUSY cycle 3 aborts the multiply
        send(8'h0F, 8'h0F, OP_MUL);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_in_busy", 32'(dbg_state_o), 32'(ST_BUSY));
        rst_ni = 1'b0;
        #1;
        chk("rst_async_outputs", 32'({in_ready_o, out_valid_o, obs()}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_after_release", 32'(in_ready_o), 32'd1);
        stray = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (out_valid_o) stray++;
        end
        chk("rst_mul_aborted", 32'(stray), 32'd0);
        @(posedge clk);
        #1;
        directed("t6_add_after_rst", 8'h03, 8'h04, OP_ADD, {8'h07, 5'b00000}, 1);
        directed("t6_illegal", 8'h5A, 8'h33, 4'hF, {8'h00, 5'b10001}, 1);

        // randomized ops with occasional output stalls
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom_range(0, FULL - 1));
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, W - 1)) : W'($urandom_range(0, FULL - 1));
            if ($urandom_range(0, 4) == 0) rop = OP_W'($urandom_range(0, 15));
            else rop = OP_W'($urandom_range(0, 9));
            stall_cycles = $urandom_range(0, 2);
            out_ready_i = (stall_cycles == 0);
            send(ra, rb, rop);
            repeat (stall_cycles) begin
                @(posedge clk);
                #1;
            end
            out_ready_i = 1'b1;
            receive("rand");
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
